// File: rtl/aes256_dec_if.sv
// Host-side bus of the AES-256 decryptor: control/data writes, round-key fetch, result.
interface aes256_dec_if #(
  parameter int unsigned N      = 16,
  parameter int unsigned NFLAGS = 8
);
  logic                wr_en;
  logic                addr;
  logic [N-1:0][7:0]   ciphertext;
  logic [NFLAGS-1:0]   flags;
  logic [3:0]          rk_idx;
  logic [N-1:0][7:0]   rk;
  logic [N-1:0][7:0]   decData;
  logic                done;
  logic                busy;

  // Host plus key-schedule store side.
  modport master (
    output wr_en, addr, ciphertext, flags, rk,
    input  rk_idx, decData, done, busy
  );

  // Decryption core side.
  modport slave (
    input  wr_en, addr, ciphertext, flags, rk,
    output rk_idx, decData, done, busy
  );
endinterface

// File: rtl/aes256_dec.sv
// Iterative AES-256 decryptor: one inverse round per clock, round keys fetched by index.
// Internally the block is a flat 128-bit vector with AES byte 0 in bits [127:120].
module aes256_dec (
  input logic         clk,
  input logic         resetn,
  aes256_dec_if.slave bus
);

  typedef enum logic [2:0] {StIdle, StInit, StRound, StFinal, StDone} state_e;

  state_e       fsm_q, fsm_d;
  logic [127:0] st_q, st_d;
  logic [127:0] dec_q, dec_d;
  logic [31:0]  ctrl_q, ctrl_d;
  logic [3:0]   rk_idx_q, rk_idx_d;
  logic         done_q, done_d;
  logic         busy_q, busy_d;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00;
    x = a;
    y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = xtime(x);
      y = y >> 1;
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254; maps 0 to 0 as AES requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] sq, acc;
    sq  = x;
    acc = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gmul(sq, sq);
      acc = gmul(acc, sq);
    end
    return acc;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    logic [15:0] t;
    t = {x, x} << n;
    return t[15:8];
  endfunction

  // Inverse S-box: inverse affine transform followed by field inversion.
  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    return gf_inv(rotl8(x, 1) ^ rotl8(x, 3) ^ rotl8(x, 6) ^ 8'h05);
  endfunction

  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127 - 8 * (4 * c + r) -: 8] = s[127 - 8 * (4 * ((c - r + 4) % 4) + r) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++) begin
      o[127 - 8 * i -: 8] = inv_sbox(s[127 - 8 * i -: 8]);
    end
    return o;
  endfunction

  function automatic logic [7:0] mul9(input logic [7:0] a);
    return xtime(xtime(xtime(a))) ^ a;
  endfunction

  function automatic logic [7:0] mul11(input logic [7:0] a);
    return xtime(xtime(xtime(a))) ^ xtime(a) ^ a;
  endfunction

  function automatic logic [7:0] mul13(input logic [7:0] a);
    return xtime(xtime(xtime(a))) ^ xtime(xtime(a)) ^ a;
  endfunction

  function automatic logic [7:0] mul14(input logic [7:0] a);
    return xtime(xtime(xtime(a))) ^ xtime(xtime(a)) ^ xtime(a);
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127 - 32 * c -: 8];
      a1 = s[119 - 32 * c -: 8];
      a2 = s[111 - 32 * c -: 8];
      a3 = s[103 - 32 * c -: 8];
      o[127 - 32 * c -: 8] = mul14(a0) ^ mul11(a1) ^ mul13(a2) ^ mul9(a3);
      o[119 - 32 * c -: 8] = mul9(a0) ^ mul14(a1) ^ mul11(a2) ^ mul13(a3);
      o[111 - 32 * c -: 8] = mul13(a0) ^ mul9(a1) ^ mul14(a2) ^ mul11(a3);
      o[103 - 32 * c -: 8] = mul11(a0) ^ mul13(a1) ^ mul9(a2) ^ mul14(a3);
    end
    return o;
  endfunction

  logic [127:0] rk_w;
  logic [127:0] sub_w;
  logic [127:0] ark_w;
  logic         start;

  assign rk_w  = bus.rk;
  assign sub_w = inv_sub_bytes(inv_shift_rows(st_q));
  assign ark_w = sub_w ^ rk_w;
  assign start = bus.wr_en && bus.addr && ctrl_q[0] && (fsm_q == StIdle);

  // Next-state for the sequencer, datapath and host-visible registers.
  always_comb begin
    fsm_d    = fsm_q;
    st_d     = st_q;
    dec_d    = dec_q;
    ctrl_d   = ctrl_q;
    rk_idx_d = rk_idx_q;
    done_d   = done_q;
    busy_d   = busy_q;

    // Control writes are accepted in any state and never abort a block.
    if (bus.wr_en && !bus.addr) ctrl_d = bus.ciphertext[3:0];

    unique case (fsm_q)
      StIdle: begin
        rk_idx_d = 4'd14;
        if (bus.flags[0]) begin
          done_d = 1'b0;
          dec_d  = '0;
        end
        // A start in the same cycle as flags[0] still proceeds.
        if (start) begin
          st_d   = bus.ciphertext;
          done_d = 1'b0;
          busy_d = 1'b1;
          fsm_d  = StInit;
        end
      end
      StInit: begin
        st_d     = st_q ^ rk_w;
        rk_idx_d = 4'd13;
        fsm_d    = StRound;
      end
      StRound: begin
        // rk_idx_q doubles as the round counter.
        st_d     = inv_mix_columns(ark_w);
        rk_idx_d = rk_idx_q - 4'd1;
        if (rk_idx_q == 4'd1) fsm_d = StFinal;
      end
      StFinal: begin
        st_d     = ark_w;
        rk_idx_d = 4'd14;
        fsm_d    = StDone;
      end
      StDone: begin
        dec_d    = st_q;
        done_d   = 1'b1;
        busy_d   = 1'b0;
        rk_idx_d = 4'd14;
        fsm_d    = StIdle;
      end
      default: fsm_d = StIdle;
    endcase
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (resetn) begin
      fsm_q    <= StIdle;
      st_q     <= '0;
      dec_q    <= '0;
      ctrl_q   <= '0;
      rk_idx_q <= 4'd14;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      fsm_q    <= fsm_d;
      st_q     <= st_d;
      dec_q    <= dec_d;
      ctrl_q   <= ctrl_d;
      rk_idx_q <= rk_idx_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.rk_idx  = rk_idx_q;
  assign bus.decData = dec_q;
  assign bus.done    = done_q;
  assign bus.busy    = busy_q;

  // Reserved control and flag bits are held but have no effect.
  logic unused_bits;
  assign unused_bits = ^{ctrl_q[31:1], bus.flags[7:1]};

endmodule

// File: tb/tb_aes256_dec.sv
// Directed self-checking bench for aes256_dec using FIPS-197 and zero-key vectors.
module tb_aes256_dec;

  localparam logic [255:0] KEY_C3  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] CT_C3   = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] PT_C3   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_ZERO = 128'hdc95c078a2408989ad48a21492842087;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  aes256_dec_if bus ();

  aes256_dec dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  // Key-schedule store model: combinational lookup by rk_idx.
  logic [127:0] rk_c3   [16];
  logic [127:0] rk_zero [16];
  logic         key_sel;
  assign bus.rk = key_sel ? rk_zero[bus.rk_idx] : rk_c3[bus.rk_idx];

  int n_checks = 0;
  int n_fail   = 0;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 0; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = xt(x);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rl(input logic [7:0] x, input int n);
    logic [15:0] t;
    t = {x, x} << n;
    return t[15:8];
  endfunction

  // Forward S-box: field inverse then affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq, inv;
    sq = x; inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gm(sq, sq);
      inv = gm(inv, sq);
    end
    return inv ^ rl(inv, 1) ^ rl(inv, 2) ^ rl(inv, 3) ^ rl(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] t);
    return {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])};
  endfunction

  // AES-256 key expansion, returns round key r.
  function automatic logic [127:0] round_key(input logic [255:0] key, input int r);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rcon;
    rcon = 8'h01;
    for (int i = 0; i < 8; i++) w[i] = key[255 - 32 * i -: 32];
    for (int i = 8; i < 60; i++) begin
      t = w[i - 1];
      if (i % 8 == 0) begin
        t = subw({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
        rcon = xt(rcon);
      end else if (i % 8 == 4) begin
        t = subw(t);
      end
      w[i] = w[i - 8] ^ t;
    end
    return {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
  endfunction

  // Stimulus primitives; called at a negedge, return at the following negedge.
  task automatic write_ctrl(input logic [31:0] v);
    bus.wr_en = 1'b1; bus.addr = 1'b0; bus.ciphertext = {96'h0, v};
    @(negedge clk);
    bus.wr_en = 1'b0;
  endtask

  task automatic drive_start(input logic [127:0] ct);
    bus.wr_en = 1'b1; bus.addr = 1'b1; bus.ciphertext = ct;
    @(negedge clk);
    bus.wr_en = 1'b0; bus.addr = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!bus.done && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!bus.done) n = -1;
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", bus.done); end
    n_checks++; if (bus.decData !== 128'h0) begin n_fail++; $display("FAIL reset_dec got %h want 0", bus.decData); end
    n_checks++; if (bus.rk_idx !== 4'd14) begin n_fail++; $display("FAIL reset_rk_idx got %0d want 14", bus.rk_idx); end
    resetn = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy got %b want 0", bus.busy); end
  endtask

  task automatic test_c3;
    logic [3:0] e;
    key_sel = 1'b0;
    write_ctrl(32'h1);
    n_checks++; if (bus.rk_idx !== 4'd14) begin n_fail++; $display("FAIL c3_idle_rk got %0d want 14", bus.rk_idx); end
    drive_start(CT_C3);
    for (int n = 0; n <= 16; n++) begin
      if (n <= 14) begin
        e = (n == 0) ? 4'd14 : (n <= 13) ? 4'(14 - n) : 4'd0;
        n_checks++;
        if (bus.rk_idx !== e) begin n_fail++; $display("FAIL c3_rk_idx n=%0d got %0d want %0d", n, bus.rk_idx, e); end
      end
      if (n <= 15) begin
        n_checks++;
        if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
          n_fail++; $display("FAIL c3_busy_done n=%0d got busy=%b done=%b want 1/0", n, bus.busy, bus.done);
        end
        @(negedge clk);
      end else begin
        n_checks++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL c3_done got %b want 1", bus.done); end
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL c3_busy_end got %b want 0", bus.busy); end
        n_checks++; if (bus.decData !== PT_C3) begin n_fail++; $display("FAIL c3_dec got %h want %h", bus.decData, PT_C3); end
      end
    end
  endtask

  task automatic test_flags_clear;
    bus.flags = 8'h01;
    @(negedge clk);
    bus.flags = 8'h00;
    n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL flags_done got %b want 0", bus.done); end
    n_checks++; if (bus.decData !== 128'h0) begin n_fail++; $display("FAIL flags_dec got %h want 0", bus.decData); end
  endtask

  task automatic test_enable_gating;
    logic seen_busy, seen_done;
    int n;
    seen_busy = 0; seen_done = 0;
    write_ctrl(32'h0);
    drive_start(CT_C3);
    for (int i = 0; i < 20; i++) begin
      if (bus.busy) seen_busy = 1;
      if (bus.done) seen_done = 1;
      @(negedge clk);
    end
    n_checks++; if (seen_busy !== 1'b0) begin n_fail++; $display("FAIL gate_busy got %b want 0", seen_busy); end
    n_checks++; if (seen_done !== 1'b0) begin n_fail++; $display("FAIL gate_done got %b want 0", seen_done); end
    write_ctrl(32'h1);
    drive_start(CT_C3);
    wait_done(n);
    n_checks++; if (n !== 16) begin n_fail++; $display("FAIL gate_latency got %0d want 16", n); end
    n_checks++; if (bus.decData !== PT_C3) begin n_fail++; $display("FAIL gate_dec got %h want %h", bus.decData, PT_C3); end
  endtask

  task automatic test_zero_key;
    int n;
    key_sel = 1'b1;
    drive_start(CT_ZERO);
    wait_done(n);
    n_checks++; if (n !== 16) begin n_fail++; $display("FAIL zero_latency got %0d want 16", n); end
    n_checks++; if (bus.decData !== 128'h0) begin n_fail++; $display("FAIL zero_dec got %h want 0", bus.decData); end
    key_sel = 1'b0;
  endtask

  task automatic test_busy_reject;
    int n;
    logic seen_busy, lost_done;
    seen_busy = 0; lost_done = 0;
    drive_start(CT_C3);
    repeat (4) @(negedge clk);
    drive_start(CT_ZERO);
    wait_done(n);
    n_checks++; if (n !== 11) begin n_fail++; $display("FAIL busy_latency got %0d want 11", n); end
    n_checks++; if (bus.decData !== PT_C3) begin n_fail++; $display("FAIL busy_dec got %h want %h", bus.decData, PT_C3); end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.busy) seen_busy = 1;
      if (!bus.done) lost_done = 1;
    end
    n_checks++; if (seen_busy !== 1'b0) begin n_fail++; $display("FAIL busy_second_op got %b want 0", seen_busy); end
    n_checks++; if (lost_done !== 1'b0) begin n_fail++; $display("FAIL busy_done_hold got %b want 0", lost_done); end
  endtask

  task automatic test_reset_mid;
    int n;
    logic seen;
    seen = 0;
    drive_start(CT_C3);
    repeat (7) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rmid_busy got %b want 0", bus.busy); end
    n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL rmid_done got %b want 0", bus.done); end
    n_checks++; if (bus.decData !== 128'h0) begin n_fail++; $display("FAIL rmid_dec got %h want 0", bus.decData); end
    n_checks++; if (bus.rk_idx !== 4'd14) begin n_fail++; $display("FAIL rmid_rk got %0d want 14", bus.rk_idx); end
    resetn = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (bus.done || bus.busy) seen = 1;
    end
    n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL rmid_no_done got %b want 0", seen); end
    // ctrl was cleared by reset, so this write must be ignored.
    drive_start(CT_C3);
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rmid_ctrl got busy=%b want 0", bus.busy); end
    write_ctrl(32'h1);
    drive_start(CT_C3);
    wait_done(n);
    n_checks++; if (n !== 16) begin n_fail++; $display("FAIL rmid_latency got %0d want 16", n); end
    n_checks++; if (bus.decData !== PT_C3) begin n_fail++; $display("FAIL rmid_dec2 got %h want %h", bus.decData, PT_C3); end
  endtask

  task automatic test_back_to_back;
    int n;
    key_sel = 1'b0;
    drive_start(CT_C3);
    wait_done(n);
    n_checks++; if (n !== 16) begin n_fail++; $display("FAIL b2b_lat1 got %0d want 16", n); end
    n_checks++; if (bus.decData !== PT_C3) begin n_fail++; $display("FAIL b2b_dec1 got %h want %h", bus.decData, PT_C3); end
    key_sel = 1'b1;
    drive_start(CT_ZERO);
    n_checks++; if (bus.done !== 1'b0 || bus.busy !== 1'b1) begin
      n_fail++; $display("FAIL b2b_start got done=%b busy=%b want 0/1", bus.done, bus.busy);
    end
    wait_done(n);
    n_checks++; if (n !== 16) begin n_fail++; $display("FAIL b2b_lat2 got %0d want 16", n); end
    n_checks++; if (bus.decData !== 128'h0) begin n_fail++; $display("FAIL b2b_dec2 got %h want 0", bus.decData); end
    bus.flags = 8'h01;
    @(negedge clk);
    bus.flags = 8'h00;
    n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL b2b_flags_done got %b want 0", bus.done); end
    n_checks++; if (bus.decData !== 128'h0) begin n_fail++; $display("FAIL b2b_flags_dec got %h want 0", bus.decData); end
    key_sel = 1'b0;
  endtask

  initial begin
    for (int r = 0; r < 15; r++) begin
      rk_c3[r]   = round_key(KEY_C3, r);
      rk_zero[r] = round_key(256'h0, r);
    end
    rk_c3[15]      = '0;
    rk_zero[15]    = '0;
    key_sel        = 1'b0;
    resetn         = 1'b1;
    bus.wr_en      = 1'b0;
    bus.addr       = 1'b0;
    bus.ciphertext = '0;
    bus.flags      = '0;

    test_reset();
    test_c3();
    test_flags_clear();
    test_enable_gating();
    test_zero_key();
    test_busy_reject();
    test_reset_mid();
    test_back_to_back();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
